// File: rtl/csr_host_master_pkg.sv
// rtl/csr_host_master_pkg.sv - host op/err encodings and CSR port command constants
package csr_host_master_pkg;

  localparam int XPR_LEN        = 32;
  localparam int CSR_ADDR_WIDTH = 12;
  localparam int CSR_CMD_WIDTH  = 3;

  localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET   = 3'd6;
  localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;

  localparam logic [1:0] HOST_OP_READ  = 2'd0;
  localparam logic [1:0] HOST_OP_WRITE = 2'd1;
  localparam logic [1:0] HOST_OP_SET   = 2'd2;
  localparam logic [1:0] HOST_OP_CLEAR = 2'd3;

  localparam logic [1:0] HOST_ERR_OK      = 2'd0;
  localparam logic [1:0] HOST_ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] HOST_ERR_TIMEOUT = 2'd2;

  function automatic logic [CSR_CMD_WIDTH-1:0] host_op_to_csr_cmd(input logic [1:0] op);
    case (op)
      HOST_OP_READ:  return CSR_READ;
      HOST_OP_WRITE: return CSR_WRITE;
      HOST_OP_SET:   return CSR_SET;
      default:       return CSR_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/csr_host_master.sv
// rtl/csr_host_master.sv - host-side master that borrows the pipeline CSR port for one access per request
module csr_host_master
  import csr_host_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [CSR_ADDR_WIDTH-1:0] req_addr,
  input  logic [XPR_LEN-1:0]        req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [XPR_LEN-1:0]        rsp_rdata,
  output logic [1:0]                rsp_err,
  output logic                      csr_req,
  input  logic                      csr_gnt,
  output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
  output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
  output logic [XPR_LEN-1:0]        csr_wdata,
  input  logic [XPR_LEN-1:0]        csr_rdata,
  input  logic                      csr_illegal
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]                state;
  logic [1:0]                op_q;
  logic [CSR_ADDR_WIDTH-1:0] addr_q;
  logic [XPR_LEN-1:0]        wdata_q;
  logic [CNT_W-1:0]          wait_cnt;
  logic [CNT_W-1:0]          wait_cnt_next;

  assign wait_cnt_next = wait_cnt + 1'b1;

  // The command is only non-idle in the granted ARB cycle so the CSR file sees exactly one access.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    csr_req   = (state == ST_ARB);
    csr_addr  = addr_q;
    csr_wdata = wdata_q;
    csr_cmd   = CSR_IDLE;
    if (state == ST_ARB && csr_gnt) begin
      csr_cmd = host_op_to_csr_cmd(op_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= HOST_OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= HOST_ERR_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            wait_cnt <= '0;
            state    <= ST_ARB;
          end
        end
        ST_ARB: begin
          // A grant in the last allowed cycle still wins over the timeout.
          if (csr_gnt) begin
            rsp_rdata <= csr_rdata;
            rsp_err   <= csr_illegal ? HOST_ERR_ILLEGAL : HOST_ERR_OK;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt_next;
            if (wait_cnt_next == CNT_LAST) begin
              rsp_rdata <= '0;
              rsp_err   <= HOST_ERR_TIMEOUT;
              state     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_host_master.sv
// tb/tb_csr_host_master.sv - randomized self-checking bench for csr_host_master with a small CSR file model
module tb_csr_host_master;
  import csr_host_master_pkg::*;

  localparam int TMO = 4;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_PRNG     = 12'h7C0;
  localparam logic [11:0] A_BAD      = 12'h7FF;
  localparam logic [31:0] BAD_RDATA  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [11:0] req_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        csr_req;
  logic        csr_gnt;
  logic [11:0] csr_addr;
  logic [2:0]  csr_cmd;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_host_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .csr_req(csr_req), .csr_gnt(csr_gnt), .csr_addr(csr_addr), .csr_cmd(csr_cmd),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal)
  );

  // Environment: a tiny CSR file with three registers, the pipeline grant source and a command monitor.
  logic [31:0] env_mscratch, env_mepc;
  logic [1:0]  env_prng;

  always_comb begin
    csr_rdata   = BAD_RDATA;
    csr_illegal = 1'b1;
    case (csr_addr)
      A_MSCRATCH: begin csr_rdata = env_mscratch;          csr_illegal = 1'b0; end
      A_MEPC:     begin csr_rdata = env_mepc;              csr_illegal = 1'b0; end
      A_PRNG:     begin csr_rdata = {30'd0, env_prng};     csr_illegal = 1'b0; end
      default:    begin csr_rdata = BAD_RDATA;             csr_illegal = 1'b1; end
    endcase
  end

  function automatic logic [31:0] env_apply(input logic [2:0] cmd, input logic [31:0] old, input logic [31:0] w);
    case (cmd)
      CSR_WRITE: return w;
      CSR_SET:   return old | w;
      CSR_CLEAR: return old & ~w;
      default:   return old;
    endcase
  endfunction

  logic [31:0] prng_new;
  assign prng_new = env_apply(csr_cmd, {30'd0, env_prng}, csr_wdata);

  always @(posedge clk) begin
    if (reset) begin
      env_mscratch <= 32'h1234_5678;
      env_mepc     <= 32'd0;
      env_prng     <= 2'b01;
    end else if (csr_cmd != CSR_IDLE && !csr_illegal) begin
      case (csr_addr)
        A_MSCRATCH: env_mscratch <= env_apply(csr_cmd, env_mscratch, csr_wdata);
        A_MEPC:     env_mepc     <= env_apply(csr_cmd, env_mepc, csr_wdata);
        A_PRNG:     env_prng     <= prng_new[1:0];
        default: ;
      endcase
    end
  end

  int gnt_delay = 1000;
  int arb_cnt = 0;
  always @(posedge clk) arb_cnt <= csr_req ? arb_cnt + 1 : 0;
  assign csr_gnt = csr_req && (arb_cnt == gnt_delay);

  int         cmd_total = 0;
  logic [2:0] last_cmd = CSR_IDLE;
  always @(negedge clk) begin
    if (csr_cmd !== CSR_IDLE) begin
      cmd_total <= cmd_total + 1;
      last_cmd  <= csr_cmd;
    end
  end

  // Reference model: register contents as plain values, updated with the host-op arithmetic.
  logic [31:0] mdl [3];

  function automatic int csr_idx(input logic [11:0] a);
    case (a)
      A_MSCRATCH: return 0;
      A_MEPC:     return 1;
      A_PRNG:     return 2;
      default:    return -1;
    endcase
  endfunction

  task automatic mdl_reset();
    mdl[0] = 32'h1234_5678;
    mdl[1] = 32'd0;
    mdl[2] = 32'd1;
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input int delay, input int hold, output logic [31:0] got_rdata);
    int          idx, exp_lat, exp_cmds, lat, c0;
    logic [31:0] exp_rdata, mask;
    logic [1:0]  exp_err;
    logic [2:0]  exp_cmd;
    idx  = csr_idx(addr);
    mask = (idx == 2) ? 32'h3 : 32'hFFFF_FFFF;
    case (op)
      HOST_OP_READ:  exp_cmd = CSR_READ;
      HOST_OP_WRITE: exp_cmd = CSR_WRITE;
      HOST_OP_SET:   exp_cmd = CSR_SET;
      default:       exp_cmd = CSR_CLEAR;
    endcase
    if (delay >= TMO) begin
      exp_lat = TMO; exp_cmds = 0; exp_rdata = 32'd0; exp_err = HOST_ERR_TIMEOUT;
    end else if (idx < 0) begin
      exp_lat = delay + 1; exp_cmds = 1; exp_rdata = BAD_RDATA; exp_err = HOST_ERR_ILLEGAL;
    end else begin
      exp_lat = delay + 1; exp_cmds = 1; exp_rdata = mdl[idx]; exp_err = HOST_ERR_OK;
      case (op)
        HOST_OP_WRITE: mdl[idx] = wd & mask;
        HOST_OP_SET:   mdl[idx] = (mdl[idx] | wd) & mask;
        HOST_OP_CLEAR: mdl[idx] = mdl[idx] & ~wd;
        default: ;
      endcase
    end

    @(negedge clk);
    gnt_delay = delay;
    c0 = cmd_total;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL accept_ready: got %b expected 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL latency: got %0d expected %0d", lat, exp_lat); end
    n_tests++;
    if (rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, exp_rdata); end
    n_tests++;
    if (rsp_err !== exp_err) begin n_fail++; $display("FAIL rsp_err: got %0d expected %0d", rsp_err, exp_err); end
    got_rdata = rsp_rdata;

    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_op = ~op; req_addr = A_MEPC; req_wdata = $urandom;
      @(posedge clk); #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b d=%h e=%0d expected v=1 d=%h e=%0d", rsp_valid, rsp_rdata, rsp_err, exp_rdata, exp_err);
      end
      n_tests++;
      if (req_ready !== 1'b0 || csr_req !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_no_accept: got req_ready=%b csr_req=%b expected 0 0", req_ready, csr_req);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_done: got rsp_valid=%b req_ready=%b expected 0 1", rsp_valid, req_ready);
    end
    n_tests++;
    if (cmd_total - c0 != exp_cmds) begin n_fail++; $display("FAIL cmd_count: got %0d expected %0d", cmd_total - c0, exp_cmds); end
    if (exp_cmds == 1) begin
      n_tests++;
      if (last_cmd !== exp_cmd) begin n_fail++; $display("FAIL cmd_value: got %0d expected %0d", last_cmd, exp_cmd); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_tests++; if (rsp_err !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_err: got %0d expected 0", rsp_err); end
    n_tests++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    n_tests++; if (csr_req !== 1'b0) begin n_fail++; $display("FAIL reset_csr_req: got %b expected 0", csr_req); end
    n_tests++; if (csr_cmd !== CSR_IDLE) begin n_fail++; $display("FAIL reset_csr_cmd: got %0d expected 0", csr_cmd); end
    reset = 1'b0;
    mdl_reset();
  endtask

  task automatic test_read_mscratch();
    logic [31:0] r;
    do_txn(HOST_OP_READ, A_MSCRATCH, 32'd0, 3, 0, r);
    n_tests++; if (r !== 32'h1234_5678) begin n_fail++; $display("FAIL mscratch_read: got %h expected 12345678", r); end
  endtask

  task automatic test_set_prng();
    logic [31:0] r;
    do_txn(HOST_OP_SET, A_PRNG, 32'h2, 0, 0, r);
    n_tests++; if (r !== 32'h1) begin n_fail++; $display("FAIL prng_set_old: got %h expected 1", r); end
    do_txn(HOST_OP_READ, A_PRNG, 32'd0, 1, 0, r);
    n_tests++; if (r !== 32'h3) begin n_fail++; $display("FAIL prng_read_back: got %h expected 3", r); end
  endtask

  task automatic test_illegal();
    logic [31:0] r;
    do_txn(HOST_OP_WRITE, A_BAD, 32'hCAFE_F00D, 2, 0, r);
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    do_txn(HOST_OP_WRITE, A_MEPC, 32'h5555_AAAA, 1000, 0, r);
    do_txn(HOST_OP_READ, A_MEPC, 32'd0, 0, 0, r);
  endtask

  task automatic test_grant_at_limit();
    logic [31:0] r;
    do_txn(HOST_OP_WRITE, A_MEPC, 32'h0BAD_F00D, TMO - 1, 0, r);
    do_txn(HOST_OP_CLEAR, A_MEPC, 32'h0000_F00D, TMO, 0, r);
    do_txn(HOST_OP_READ, A_MEPC, 32'd0, TMO - 1, 0, r);
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    do_txn(HOST_OP_READ, A_MSCRATCH, 32'd0, 2, 5, r);
  endtask

  task automatic test_reset_mid();
    int c0;
    @(negedge clk);
    gnt_delay = 1000;
    c0 = cmd_total;
    req_valid = 1'b1; req_op = HOST_OP_WRITE; req_addr = A_MSCRATCH; req_wdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (csr_req !== 1'b1) begin n_fail++; $display("FAIL mid_in_arb: got csr_req=%b expected 1", csr_req); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_reset();
    n_tests++;
    if (req_ready !== 1'b1 || csr_req !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got req_ready=%b csr_req=%b rsp_valid=%b expected 1 0 0", req_ready, csr_req, rsp_valid);
    end
    for (int k = 0; k < TMO + 2; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (rsp_valid !== 1'b0 || csr_req !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_quiet: got rsp_valid=%b csr_req=%b expected 0 0", rsp_valid, csr_req);
      end
    end
    n_tests++; if (cmd_total != c0) begin n_fail++; $display("FAIL mid_reset_cmds: got %0d expected 0", cmd_total - c0); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [11:0] a;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: a = A_MSCRATCH;
        1: a = A_MEPC;
        2: a = A_PRNG;
        default: a = A_BAD;
      endcase
      do_txn(2'($urandom_range(0, 3)), a, $urandom, int'($urandom_range(0, TMO + 1)),
             int'($urandom_range(0, 2)), r);
    end
  endtask

  initial begin
    test_reset();
    test_read_mscratch();
    test_set_prng();
    test_illegal();
    test_timeout();
    test_grant_at_limit();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
